// File: rtl/md_sequencer.sv
// Iterative signed multiply/divide unit: radix-2 Booth multiply and restoring divide,
// one bit per clock, with a busy/done handshake toward the control unit.
module md_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             op_q;
  logic             neg_q;
  logic             neg_r;
  logic             q_m1;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] p_hi;
  logic [WIDTH-1:0] p_lo;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   div_trial;

  always_comb begin
    abs_a = a[WIDTH-1] ? -a : a;
    abs_b = b[WIDTH-1] ? -b : b;
    // P_hi is sign-extended by one bit so the add/sub cannot overflow before the shift
    booth_sum = {p_hi[WIDTH-1], p_hi};
    case ({p_lo[0], q_m1})
      2'b01:   booth_sum = {p_hi[WIDTH-1], p_hi} + {mcand[WIDTH-1], mcand};
      2'b10:   booth_sum = {p_hi[WIDTH-1], p_hi} - {mcand[WIDTH-1], mcand};
      default: booth_sum = {p_hi[WIDTH-1], p_hi};
    endcase
    // Partial remainder shifted left with the next dividend bit; a set MSB means it went negative
    div_trial = {p_hi, p_lo[WIDTH-1]} - {1'b0, mcand};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      count    <= '0;
      op_q     <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      q_m1     <= 1'b0;
      mcand    <= '0;
      p_hi     <= '0;
      p_lo     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            op_q     <= op;
            div_zero <= 1'b0;
            count    <= '0;
            busy     <= 1'b1;
            if (op && (b == '0)) begin
              hi       <= a;
              lo       <= '1;
              div_zero <= 1'b1;
              done     <= 1'b1;
              state    <= DONE;
            end else begin
              q_m1  <= 1'b0;
              p_hi  <= '0;
              neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
              neg_r <= a[WIDTH-1];
              if (op) begin
                mcand <= abs_b;
                p_lo  <= abs_a;
              end else begin
                mcand <= a;
                p_lo  <= b;
              end
              state <= RUN;
            end
          end
        end
        RUN: begin
          count <= count + 1'b1;
          if (op_q) begin
            if (!div_trial[WIDTH]) begin
              p_hi <= div_trial[WIDTH-1:0];
            end else begin
              p_hi <= {p_hi[WIDTH-2:0], p_lo[WIDTH-1]};
            end
            p_lo <= {p_lo[WIDTH-2:0], ~div_trial[WIDTH]};
          end else begin
            p_hi <= booth_sum[WIDTH:1];
            p_lo <= {booth_sum[0], p_lo[WIDTH-1:1]};
            q_m1 <= p_lo[0];
          end
          if (count == CNT_W'(WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (op_q) begin
            lo <= neg_q ? -p_lo : p_lo;
            hi <= neg_r ? -p_hi : p_hi;
          end else begin
            lo <= p_lo;
            hi <= p_hi;
          end
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
